// File: rtl/cfg_bank_loader_if.sv
// Word-serial configuration stream and loader status, grouped for the
// cfg_bank_loader. The master drives the stream; the loader is the slave.
interface cfg_bank_loader_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 7
);
  logic              cfg_start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [IDX_W-1:0]  word_cnt;

  modport master (
    output cfg_start, cfg_data, cfg_valid,
    input  cfg_ready, cfg_busy, cfg_done, cfg_err, word_cnt
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid,
    output cfg_ready, cfg_busy, cfg_done, cfg_err, word_cnt
  );
endinterface

// File: rtl/cfg_bank_loader.sv
// Memory-bank configuration loader. Accepts one DATA_W-bit word per handshake
// and programs the matching slice of the tile's bl/wl buses with a
// setup / WL_PULSE-cycle strobe / hold sequence. All outputs are registered.
module cfg_bank_loader #(
  parameter int NUM_CELLS = 1260,
  parameter int DATA_W    = 16,
  parameter int WL_PULSE  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cfg_bank_loader_if.slave     cfg,
  output logic [0:NUM_CELLS-1] bl,
  output logic [0:NUM_CELLS-1] wl
);

  localparam int NUM_WORDS = (NUM_CELLS + DATA_W - 1) / DATA_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PC_W      = $clog2(WL_PULSE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [0:NUM_CELLS-1] bl_q, bl_d;
  logic [0:NUM_CELLS-1] wl_q, wl_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
  logic [PC_W-1:0]      pulse_cnt_q, pulse_cnt_d;

  // One-hot decode of the current word, then the per-cell mask and data it
  // selects. Cells past NUM_CELLS are simply never generated, so the unused
  // top bits of a partial last word cannot reach bl or wl.
  logic [NUM_WORDS-1:0] word_sel;
  logic [0:NUM_CELLS-1] word_mask;
  logic [0:NUM_CELLS-1] word_bits;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_sel
    assign word_sel[w] = (word_cnt_q == IDX_W'(w));
  end

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    assign word_mask[c] = word_sel[c / DATA_W];
    assign word_bits[c] = word_sel[c / DATA_W] & cfg.cfg_data[c % DATA_W];
  end

  logic load_active;
  assign load_active = (state_q == S_ACCEPT) || (state_q == S_SETUP) ||
                       (state_q == S_PULSE)  || (state_q == S_HOLD);

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves a value unassigned and infers a latch.
    state_d     = state_q;
    bl_d        = bl_q;
    wl_d        = '0;
    ready_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    word_cnt_d  = word_cnt_q;
    pulse_cnt_d = pulse_cnt_q;

    if (load_active && cfg.cfg_start) begin
      // Abort wins over everything, including a coincident handshake.
      state_d     = S_IDLE;
      bl_d        = '0;
      err_d       = 1'b1;
      busy_d      = 1'b0;
      word_cnt_d  = '0;
      pulse_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg.cfg_start) begin
            state_d    = S_ACCEPT;
            ready_d    = 1'b1;
            bl_d       = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            word_cnt_d = '0;
          end
        end
        S_ACCEPT: begin
          if (cfg.cfg_valid && ready_q) begin
            state_d = S_SETUP;
            bl_d    = word_bits;
          end else begin
            ready_d = 1'b1;
          end
        end
        S_SETUP: begin
          state_d     = S_PULSE;
          wl_d        = word_mask;
          pulse_cnt_d = PC_W'(1);
        end
        S_PULSE: begin
          if (pulse_cnt_q == PC_W'(WL_PULSE)) begin
            state_d     = S_HOLD;
            pulse_cnt_d = '0;
          end else begin
            wl_d        = word_mask;
            pulse_cnt_d = pulse_cnt_q + PC_W'(1);
          end
        end
        S_HOLD: begin
          if (word_cnt_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = S_DONE;
            bl_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ACCEPT;
            ready_d    = 1'b1;
            word_cnt_d = word_cnt_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears wl immediately, even mid-strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bl_q        <= '0;
      wl_q        <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      pulse_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      word_cnt_q  <= word_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_busy  = busy_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign cfg.word_cnt  = word_cnt_q;
  assign bl            = bl_q;
  assign wl            = wl_q;

endmodule

// File: tb/tb_cfg_bank_loader.sv
// Bench for cfg_bank_loader: a 40-cell instance for directed protocol cases
// and a default 1260-cell instance for a full load. Every accepted word pushes
// its expected strobe into a queue; per-instance monitors pop and compare on
// each wl rising edge and check strobe length and bl stability.
module tb_cfg_bank_loader;
  localparam int DW      = 16;
  localparam int WLP     = 2;
  localparam int S_CELLS = 40;
  localparam int S_IDX   = 2;
  localparam int D_CELLS = 1260;
  localparam int D_IDX   = 7;
  localparam int D_IW    = 11;

  typedef struct {
    int          word;
    logic [DW-1:0] data;
    int          len;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  cfg_bank_loader_if #(.DATA_W(DW), .IDX_W(S_IDX)) s_if ();
  cfg_bank_loader_if #(.DATA_W(DW), .IDX_W(D_IDX)) d_if ();

  logic [0:S_CELLS-1] s_bl, s_wl;
  logic [0:D_CELLS-1] d_bl, d_wl;

  cfg_bank_loader #(.NUM_CELLS(S_CELLS), .DATA_W(DW), .WL_PULSE(WLP)) dut_s (
    .clk(clk), .reset(reset), .cfg(s_if), .bl(s_bl), .wl(s_wl)
  );

  cfg_bank_loader #(.NUM_CELLS(D_CELLS), .DATA_W(DW), .WL_PULSE(WLP)) dut_d (
    .clk(clk), .reset(reset), .cfg(d_if), .bl(d_bl), .wl(d_wl)
  );

  exp_t q_s[$];
  exp_t q_d[$];
  int   s_hs_cyc, d_hs_cyc;
  int   s_strobes = 0, d_strobes = 0;
  int   cell_hits[D_CELLS];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference strobe for one word: data bits (strobe=0) or wl mask (strobe=1).
  function automatic logic [0:D_CELLS-1] exp_vec(input exp_t e, input bit strobe, input int cells);
    logic [0:D_CELLS-1] v;
    logic [DW-1:0] d;
    v = '0;
    d = e.data;
    for (int c = 0; c < cells; c++)
      if (c / DW == e.word) v[D_IW'(c)] = strobe ? 1'b1 : d[4'(c % DW)];
    return v;
  endfunction

  // Monitor for the 40-cell instance.
  logic [0:S_CELLS-1] s_prev_bl = '0;
  bit   s_prev_on = 1'b0, s_have = 1'b0;
  int   s_len = 0;
  exp_t s_cur;
  always @(negedge clk) begin : mon_s
    logic [0:D_CELLS-1] v;
    if (s_wl != '0) begin
      if (!s_prev_on) begin
        s_strobes++;
        s_len = 1;
        check("s_bl_changed_into_strobe", longint'(s_bl != s_prev_bl), 0);
        if (q_s.size() == 0) begin
          s_have = 1'b0;
          check("s_unexpected_strobe", 1, 0);
        end else begin
          s_cur  = q_s.pop_front();
          s_have = 1'b1;
          v = exp_vec(s_cur, 1'b0, S_CELLS);
          check("s_bl_bits_wrong", $countones(s_bl ^ v[0:S_CELLS-1]), 0);
          v = exp_vec(s_cur, 1'b1, S_CELLS);
          check("s_wl_bits_wrong", $countones(s_wl ^ v[0:S_CELLS-1]), 0);
        end
      end else begin
        s_len++;
        check("s_bl_changed_in_strobe", longint'(s_bl != s_prev_bl), 0);
      end
    end else if (s_prev_on && s_have) begin
      check("s_pulse_len", s_len, s_cur.len);
    end
    s_prev_on = (s_wl != '0);
    s_prev_bl = s_bl;
  end

  // Monitor for the default instance, also tallying strobes per cell.
  logic [0:D_CELLS-1] d_prev_bl = '0;
  bit   d_prev_on = 1'b0, d_have = 1'b0;
  int   d_len = 0;
  exp_t d_cur;
  always @(negedge clk) begin : mon_d
    logic [0:D_CELLS-1] v;
    if (d_wl != '0) begin
      if (!d_prev_on) begin
        d_strobes++;
        d_len = 1;
        for (int c = 0; c < D_CELLS; c++) if (d_wl[D_IW'(c)]) cell_hits[c]++;
        check("d_bl_changed_into_strobe", longint'(d_bl != d_prev_bl), 0);
        if (q_d.size() == 0) begin
          d_have = 1'b0;
          check("d_unexpected_strobe", 1, 0);
        end else begin
          d_cur  = q_d.pop_front();
          d_have = 1'b1;
          v = exp_vec(d_cur, 1'b0, D_CELLS);
          check("d_bl_bits_wrong", $countones(d_bl ^ v), 0);
          v = exp_vec(d_cur, 1'b1, D_CELLS);
          check("d_wl_bits_wrong", $countones(d_wl ^ v), 0);
        end
      end else begin
        d_len++;
        check("d_bl_changed_in_strobe", longint'(d_bl != d_prev_bl), 0);
      end
    end else if (d_prev_on && d_have) begin
      check("d_pulse_len", d_len, d_cur.len);
    end
    d_prev_on = (d_wl != '0);
    d_prev_bl = d_bl;
  end

  task automatic start_s();
    @(posedge clk); #1;
    s_if.cfg_start = 1'b1;
    @(posedge clk); #1;
    s_if.cfg_start = 1'b0;
  endtask

  task automatic start_d();
    @(posedge clk); #1;
    d_if.cfg_start = 1'b1;
    @(posedge clk); #1;
    d_if.cfg_start = 1'b0;
  endtask

  // Offer one word; len=0 means the strobe is not expected to be observed.
  task automatic send_s(input logic [DW-1:0] data, input int word, input int len);
    s_if.cfg_data  = data;
    s_if.cfg_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_if.cfg_ready) begin
        if (len > 0) q_s.push_back('{word, data, len});
        s_hs_cyc = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    check("s_handshake_timeout", 0, 1);
  endtask

  task automatic send_d(input logic [DW-1:0] data, input int word, input int len);
    d_if.cfg_data  = data;
    d_if.cfg_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (d_if.cfg_ready) begin
        if (len > 0) q_d.push_back('{word, data, len});
        d_hs_cyc = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    check("d_handshake_timeout", 0, 1);
  endtask

  task automatic wait_done_s(output int at);
    at = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_if.cfg_done) begin
        at = cyc;
        return;
      end
    end
    check("s_done_timeout", 0, 1);
  endtask

  task automatic wait_done_d(output int at);
    at = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (d_if.cfg_done) begin
        at = cyc;
        return;
      end
    end
    check("d_done_timeout", 0, 1);
  endtask

  task automatic check_s_idle(input string tag, input bit err);
    check({tag, "_ready"}, s_if.cfg_ready, 0);
    check({tag, "_busy"}, s_if.cfg_busy, 0);
    check({tag, "_done"}, s_if.cfg_done, 0);
    check({tag, "_err"}, s_if.cfg_err, err);
    check({tag, "_word_cnt"}, s_if.word_cnt, 0);
    check({tag, "_bl_ones"}, $countones(s_bl), 0);
    check({tag, "_wl_ones"}, $countones(s_wl), 0);
  endtask

  initial begin
    int hs0, t;
    logic [DW-1:0] data;
    s_if.cfg_start = 1'b0; s_if.cfg_valid = 1'b0; s_if.cfg_data = '0;
    d_if.cfg_start = 1'b0; d_if.cfg_valid = 1'b0; d_if.cfg_data = '0;
    for (int c = 0; c < D_CELLS; c++) cell_hits[c] = 0;

    // Reset state.
    #2 reset = 1'b0;
    @(negedge clk);
    check_s_idle("reset", 1'b0);
    check("reset_d_ready", d_if.cfg_ready, 0);
    check("reset_d_wl_ones", $countones(d_wl), 0);
    @(negedge clk);
    reset = 1'b1;

    // Three back-to-back words on 40 cells; the third is partial.
    start_s();
    send_s(16'hA5A5, 0, WLP);
    hs0 = s_hs_cyc;
    send_s(16'h0F0F, 1, WLP);
    send_s(16'h00C3, 2, WLP);
    s_if.cfg_valid = 1'b0;
    wait_done_s(t);
    check("s_done_latency", t - hs0, 15);
    check("s_done_busy", s_if.cfg_busy, 0);
    check("s_done_bl_ones", $countones(s_bl), 0);
    check("s_strobe_count", s_strobes, 3);
    check("s_queue_drained", q_s.size(), 0);

    // Valid while DONE: nothing accepted, done stays set.
    s_if.cfg_data  = 16'hFFFF;
    s_if.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_valid_ready", s_if.cfg_ready, 0);
      check("done_valid_done", s_if.cfg_done, 1);
      check("done_valid_bl_ones", $countones(s_bl), 0);
    end
    s_if.cfg_valid = 1'b0;

    // Ten-cycle stall in ACCEPT of word 1.
    start_s();
    send_s(16'h1234, 0, WLP);
    hs0 = s_hs_cyc;
    s_if.cfg_valid = 1'b0;
    for (int n = 0; n < 50 && !s_if.cfg_ready; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_ready", s_if.cfg_ready, 1);
      check("stall_busy", s_if.cfg_busy, 1);
      check("stall_wl_ones", $countones(s_wl), 0);
      check("stall_word_cnt", s_if.word_cnt, 1);
    end
    @(posedge clk); #1;
    send_s(16'h5678, 1, WLP);
    send_s(16'h9ABC, 2, WLP);
    s_if.cfg_valid = 1'b0;
    wait_done_s(t);
    check("s_stall_latency", t - hs0, 25);

    // Abort during the first PULSE cycle of word 1.
    start_s();
    send_s(16'hFFFF, 0, WLP);
    send_s(16'h8001, 1, 1);
    s_if.cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_wl_high_before", longint'(s_wl != '0), 1);
    s_if.cfg_start = 1'b1;
    @(posedge clk); #1;
    s_if.cfg_start = 1'b0;
    @(negedge clk);
    check_s_idle("abort", 1'b1);

    start_s();
    @(negedge clk);
    check("restart_err", s_if.cfg_err, 0);
    check("restart_ready", s_if.cfg_ready, 1);
    check("restart_busy", s_if.cfg_busy, 1);
    check("restart_word_cnt", s_if.word_cnt, 0);

    // Start coincident with a handshake: the word is discarded.
    s_if.cfg_data  = 16'h7777;
    s_if.cfg_valid = 1'b1;
    s_if.cfg_start = 1'b1;
    @(posedge clk); #1;
    s_if.cfg_start = 1'b0;
    s_if.cfg_valid = 1'b0;
    @(negedge clk);
    check_s_idle("coincident", 1'b1);

    start_s();
    send_s(16'h0001, 0, WLP);
    hs0 = s_hs_cyc;
    send_s(16'h8000, 1, WLP);
    send_s(16'h0055, 2, WLP);
    s_if.cfg_valid = 1'b0;
    wait_done_s(t);
    check("reload_latency", t - hs0, 15);
    check("reload_err", s_if.cfg_err, 0);

    // Reset asserted mid-PULSE drops wl at once.
    start_s();
    send_s(16'hBEEF, 0, 0);
    s_if.cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_wl_high_before", longint'(s_wl != '0), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_wl_ones", $countones(s_wl), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_s_idle("after_reset", 1'b0);

    // Valid while IDLE: nothing accepted.
    s_if.cfg_data  = 16'hFFFF;
    s_if.cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_valid_ready", s_if.cfg_ready, 0);
      check("idle_valid_done", s_if.cfg_done, 0);
      check("idle_valid_bl_ones", $countones(s_bl), 0);
    end
    s_if.cfg_valid = 1'b0;

    // Full default load, always-valid input; last word has junk in [15:12].
    start_d();
    for (int w = 0; w < 79; w++) begin
      data = 16'($urandom);
      if (w == 78) data[15:12] = 4'hF;
      send_d(data, w, WLP);
      if (w == 0) hs0 = d_hs_cyc;
    end
    d_if.cfg_valid = 1'b0;
    wait_done_d(t);
    check("d_total_cycles", t - hs0, 79 * 5);
    check("d_strobe_count", d_strobes, 79);
    check("d_queue_drained", q_d.size(), 0);
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < D_CELLS; c++) if (cell_hits[c] != 1) bad++;
      check("d_cells_not_strobed_once", bad, 0);
    end
    check("d_done_bl_ones", $countones(d_bl), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
